// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus: redirect/hazard controls, instruction ROM port
// and the registered IF/ID fields handed to decode.
interface fetch_pc_ctrl_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     stall_f;
    logic                     flush_d;
    logic [1:0]               pcsrc;
    logic [ADDRESS_WIDTH-1:0] pc_target;
    logic [ADDRESS_WIDTH-1:0] jalr_target;
    logic [DATA_WIDTH-1:0]    instr_f;
    logic [ADDRESS_WIDTH-1:0] pc_f;
    logic [DATA_WIDTH-1:0]    instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d;
    logic                     valid_d;
    logic                     fault;

    modport master (
        input  stall_f, flush_d, pcsrc, pc_target, jalr_target, instr_f,
        output pc_f, instr_d, pc_d, pc_plus4_d, valid_d, fault
    );

    modport slave (
        output stall_f, flush_d, pcsrc, pc_target, jalr_target, instr_f,
        input  pc_f, instr_d, pc_d, pc_plus4_d, valid_d, fault
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// PC sequencing and IF/ID register with sticky fetch-fault halt.
// Only a synchronous reset leaves the HALT state.
module fetch_pc_ctrl #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [ADDRESS_WIDTH-1:0] ROM_LAST      = 'hFFF
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_ctrl_if.master bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    localparam logic [DATA_WIDTH-1:0]    NOP      = DATA_WIDTH'(32'h00000013);
    localparam logic [ADDRESS_WIDTH-1:0] PC_LIMIT = ROM_LAST - ADDRESS_WIDTH'(3);
    localparam logic [ADDRESS_WIDTH-1:0] FOUR     = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] BIT0     = ADDRESS_WIDTH'(1);

    logic [0:0]               state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0]    instr_q;
    logic [ADDRESS_WIDTH-1:0] pc_d_q;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_q;
    logic                     valid_q;
    logic                     fault_q;
    logic                     redirect;
    logic                     bad_pc;
    logic                     fault_cond;

    assign pc_plus4 = pc + FOUR;
    assign redirect = (bus.pcsrc == 2'b01) || (bus.pcsrc == 2'b10);
    assign bad_pc   = (pc[1:0] != 2'b00) || (pc > PC_LIMIT);

    // Only a fetch that would really be consumed may fault.
    assign fault_cond = (state == RUN) && !bus.stall_f && !redirect
                        && !bus.flush_d && bad_pc;

    always_comb begin
        pc_next = pc_plus4;
        case (bus.pcsrc)
            2'b01:   pc_next = bus.pc_target;
            2'b10:   pc_next = bus.jalr_target & ~BIT0;
            default: if (bus.stall_f || fault_cond) pc_next = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            fault_q    <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            pc_d_q     <= '0;
            pc_plus4_q <= '0;
        end else if (state == RUN) begin
            pc <= pc_next;
            if (fault_cond) begin
                state   <= HALT;
                fault_q <= 1'b1;
            end
            if (bus.flush_d || fault_cond) begin
                valid_q    <= 1'b0;
                instr_q    <= NOP;
                pc_d_q     <= '0;
                pc_plus4_q <= '0;
            end else if (!bus.stall_f) begin
                valid_q    <= 1'b1;
                instr_q    <= bus.instr_f;
                pc_d_q     <= pc;
                pc_plus4_q <= pc_plus4;
            end
        end
    end

    assign bus.pc_f       = pc;
    assign bus.instr_d    = instr_q;
    assign bus.pc_d       = pc_d_q;
    assign bus.pc_plus4_d = pc_plus4_q;
    assign bus.valid_d    = valid_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a combinational ROM model.
// Inputs change 1ns after each rising edge; outputs checked there too.
module tb_fetch_pc_ctrl;
    logic clk;
    logic rst;
    int   cnt;
    int   errs;

    fetch_pc_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_pc_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.instr_f = rom(bus.pc_f);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_f     = 1'b0;
        bus.flush_d     = 1'b0;
        bus.pcsrc       = 2'b00;
        bus.pc_target   = '0;
        bus.jalr_target = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        cnt++; if (bus.pc_f !== 32'h0) begin errs++; $display("FAIL rst_pc got %h want 0", bus.pc_f); end
        cnt++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL rst_fault got %b want 0", bus.fault); end
        cnt++; if (bus.valid_d !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", bus.valid_d); end
        cnt++; if (bus.instr_d !== 32'h13) begin errs++; $display("FAIL rst_instr got %h want 00000013", bus.instr_d); end
        cnt++; if (bus.pc_d !== 32'h0 || bus.pc_plus4_d !== 32'h0) begin errs++; $display("FAIL rst_pcd got %h/%h want 0/0", bus.pc_d, bus.pc_plus4_d); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        step();
        cnt++; if (bus.pc_f !== 32'h4) begin errs++; $display("FAIL seq_pc4 got %h want 4", bus.pc_f); end
        cnt++; if (bus.instr_d !== rom(32'h0) || bus.valid_d !== 1'b1) begin errs++; $display("FAIL seq_d0 got %h/%b want %h/1", bus.instr_d, bus.valid_d, rom(32'h0)); end
        step();
        cnt++; if (bus.pc_f !== 32'h8) begin errs++; $display("FAIL seq_pc8 got %h want 8", bus.pc_f); end
        cnt++; if (bus.pc_d !== 32'h4 || bus.pc_plus4_d !== 32'h8) begin errs++; $display("FAIL seq_pcd got %h/%h want 4/8", bus.pc_d, bus.pc_plus4_d); end
        cnt++; if (bus.valid_d !== 1'b1 || bus.instr_d !== rom(32'h4)) begin errs++; $display("FAIL seq_d4 got %h/%b want %h/1", bus.instr_d, bus.valid_d, rom(32'h4)); end
    endtask

    task automatic test_stall();
        bus.stall_f = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            cnt++; if (bus.pc_f !== 32'h8) begin errs++; $display("FAIL stall_pc[%0d] got %h want 8", i, bus.pc_f); end
            cnt++; if (bus.pc_d !== 32'h4 || bus.instr_d !== rom(32'h4) || bus.valid_d !== 1'b1) begin errs++; $display("FAIL stall_d[%0d] got %h/%h/%b want 4/%h/1", i, bus.pc_d, bus.instr_d, bus.valid_d, rom(32'h4)); end
        end
        bus.stall_f = 1'b0;
        step();
        cnt++; if (bus.pc_f !== 32'hC) begin errs++; $display("FAIL stall_rel got %h want c", bus.pc_f); end
        cnt++; if (bus.pc_d !== 32'h8 || bus.pc_plus4_d !== 32'hC) begin errs++; $display("FAIL stall_reld got %h/%h want 8/c", bus.pc_d, bus.pc_plus4_d); end
    endtask

    task automatic test_redirect();
        bus.pcsrc       = 2'b10;
        bus.jalr_target = 32'h21;
        bus.stall_f     = 1'b1;
        bus.flush_d     = 1'b1;
        step();
        cnt++; if (bus.pc_f !== 32'h20) begin errs++; $display("FAIL jalr_pc got %h want 20", bus.pc_f); end
        cnt++; if (bus.valid_d !== 1'b0 || bus.instr_d !== 32'h13 || bus.pc_d !== 32'h0) begin errs++; $display("FAIL jalr_flush got %b/%h/%h want 0/00000013/0", bus.valid_d, bus.instr_d, bus.pc_d); end
        cnt++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL jalr_fault got %b want 0", bus.fault); end
        idle();
        step();
        cnt++; if (bus.pc_f !== 32'h24 || bus.pc_d !== 32'h20 || bus.valid_d !== 1'b1) begin errs++; $display("FAIL jalr_next got %h/%h/%b want 24/20/1", bus.pc_f, bus.pc_d, bus.valid_d); end
    endtask

    task automatic test_wrap_and_reserved();
        bus.pcsrc     = 2'b01;
        bus.pc_target = 32'hFFFF_FFFC;
        bus.flush_d   = 1'b1;
        step();
        cnt++; if (bus.pc_f !== 32'hFFFF_FFFC || bus.fault !== 1'b0) begin errs++; $display("FAIL wrap_pc got %h/%b want fffffffc/0", bus.pc_f, bus.fault); end
        bus.flush_d   = 1'b0;
        bus.pc_target = 32'h40;
        step();
        cnt++; if (bus.pc_plus4_d !== 32'h0 || bus.pc_d !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_plus4 got %h/%h want fffffffc/0", bus.pc_d, bus.pc_plus4_d); end
        cnt++; if (bus.pc_f !== 32'h40 || bus.fault !== 1'b0) begin errs++; $display("FAIL wrap_redir got %h/%b want 40/0", bus.pc_f, bus.fault); end
        bus.pcsrc = 2'b11;
        bus.pc_target = 32'h80;
        step();
        cnt++; if (bus.pc_f !== 32'h44 || bus.pc_d !== 32'h40) begin errs++; $display("FAIL rsvd_pc got %h/%h want 44/40", bus.pc_f, bus.pc_d); end
        idle();
    endtask

    task automatic test_out_of_range();
        bus.pcsrc     = 2'b01;
        bus.pc_target = 32'hFFC;
        step();
        cnt++; if (bus.pc_f !== 32'hFFC || bus.fault !== 1'b0) begin errs++; $display("FAIL oor_load got %h/%b want ffc/0", bus.pc_f, bus.fault); end
        idle();
        step();
        cnt++; if (bus.pc_f !== 32'h1000 || bus.pc_d !== 32'hFFC || bus.valid_d !== 1'b1 || bus.fault !== 1'b0) begin errs++; $display("FAIL oor_last got %h/%h/%b/%b want 1000/ffc/1/0", bus.pc_f, bus.pc_d, bus.valid_d, bus.fault); end
        step();
        cnt++; if (bus.fault !== 1'b1 || bus.pc_f !== 32'h1000) begin errs++; $display("FAIL oor_fault got %b/%h want 1/1000", bus.fault, bus.pc_f); end
        cnt++; if (bus.valid_d !== 1'b0 || bus.instr_d !== 32'h13) begin errs++; $display("FAIL oor_nop got %b/%h want 0/00000013", bus.valid_d, bus.instr_d); end
        bus.pcsrc     = 2'b01;
        bus.pc_target = 32'h80;
        bus.flush_d   = 1'b1;
        step();
        bus.flush_d = 1'b0;
        bus.stall_f = 1'b1;
        step();
        bus.pcsrc = 2'b00;
        bus.stall_f = 1'b0;
        step();
        cnt++; if (bus.pc_f !== 32'h1000 || bus.fault !== 1'b1 || bus.valid_d !== 1'b0) begin errs++; $display("FAIL halt_hold got %h/%b/%b want 1000/1/0", bus.pc_f, bus.fault, bus.valid_d); end
    endtask

    task automatic test_reset_halt();
        #2;
        rst = 1'b1;
        bus.pcsrc = 2'b01;
        bus.pc_target = 32'h80;
        #1;
        cnt++; if (bus.pc_f !== 32'h1000 || bus.fault !== 1'b1) begin errs++; $display("FAIL rst_sync got %h/%b want 1000/1", bus.pc_f, bus.fault); end
        step();
        cnt++; if (bus.pc_f !== 32'h0 || bus.fault !== 1'b0 || bus.valid_d !== 1'b0) begin errs++; $display("FAIL rst_halt got %h/%b/%b want 0/0/0", bus.pc_f, bus.fault, bus.valid_d); end
        rst = 1'b0;
        idle();
        step();
        cnt++; if (bus.pc_f !== 32'h4 || bus.valid_d !== 1'b1 || bus.pc_d !== 32'h0) begin errs++; $display("FAIL rst_resume got %h/%b/%h want 4/1/0", bus.pc_f, bus.valid_d, bus.pc_d); end
    endtask

    task automatic test_misaligned();
        bus.pcsrc     = 2'b01;
        bus.pc_target = 32'h6;
        bus.flush_d   = 1'b1;
        step();
        cnt++; if (bus.pc_f !== 32'h6 || bus.fault !== 1'b0) begin errs++; $display("FAIL mis_load got %h/%b want 6/0", bus.pc_f, bus.fault); end
        idle();
        bus.stall_f = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            cnt++; if (bus.fault !== 1'b0 || bus.pc_f !== 32'h6) begin errs++; $display("FAIL mis_stall[%0d] got %b/%h want 0/6", i, bus.fault, bus.pc_f); end
        end
        bus.stall_f = 1'b0;
        step();
        cnt++; if (bus.fault !== 1'b1 || bus.valid_d !== 1'b0 || bus.pc_f !== 32'h6) begin errs++; $display("FAIL mis_fault got %b/%b/%h want 1/0/6", bus.fault, bus.valid_d, bus.pc_f); end
    endtask

    task automatic test_reset_mid_stall();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        bus.stall_f = 1'b1;
        rst = 1'b1;
        step();
        cnt++; if (bus.pc_f !== 32'h0 || bus.valid_d !== 1'b0 || bus.instr_d !== 32'h13) begin errs++; $display("FAIL rst_stall got %h/%b/%h want 0/0/00000013", bus.pc_f, bus.valid_d, bus.instr_d); end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        cnt  = 0;
        errs = 0;
        rst  = 1'b1;
        idle();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap_and_reserved();
        test_out_of_range();
        test_reset_halt();
        test_misaligned();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", cnt, errs);
        $finish;
    end
endmodule
